// File: rtl/riscv_pkg.sv
// Shared RV32I encoding definitions: format codes, opcodes, immediate ranges
// and the decoded-field bundle carried through the encoder pipeline.
package riscv_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;

  localparam int signed IMM12_MIN = -2048;
  localparam int signed IMM12_MAX = 2047;
  localparam int signed IMMB_MIN  = -4096;
  localparam int signed IMMB_MAX  = 4094;
  localparam int signed IMMJ_MIN  = -1048576;
  localparam int signed IMMJ_MAX  = 1048574;

  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } fields_t;

endpackage

// File: rtl/instr_encoder_imm_pack.sv
// Combinational packer: scatters fields and immediate into an RV32I word and
// flags encodings that cannot be represented; a flagged word is forced to zero.
module imm_pack
  import riscv_pkg::*;
(
  input  fields_t     fields_i,
  output logic [31:0] instr_o,
  output logic        err_o
);

  logic signed [31:0] imm_s;
  logic [31:0]        imm;
  logic [31:0]        word;
  logic               bad;

  assign imm   = fields_i.imm;
  assign imm_s = fields_i.imm;

  always_comb begin
    word = '0;
    bad  = 1'b0;
    case (fields_i.fmt)
      FMT_R: word = {fields_i.funct7, fields_i.rs2, fields_i.rs1, fields_i.funct3,
                     fields_i.rd, fields_i.opcode};
      FMT_I: begin
        word = {imm[11:0], fields_i.rs1, fields_i.funct3, fields_i.rd, fields_i.opcode};
        bad  = (imm_s < IMM12_MIN) || (imm_s > IMM12_MAX);
      end
      FMT_S: begin
        word = {imm[11:5], fields_i.rs2, fields_i.rs1, fields_i.funct3, imm[4:0],
                fields_i.opcode};
        bad  = (imm_s < IMM12_MIN) || (imm_s > IMM12_MAX);
      end
      FMT_B: begin
        word = {imm[12], imm[10:5], fields_i.rs2, fields_i.rs1, fields_i.funct3,
                imm[4:1], imm[11], fields_i.opcode};
        bad  = (imm_s < IMMB_MIN) || (imm_s > IMMB_MAX) || imm[0];
      end
      FMT_U: begin
        word = {imm[31:12], fields_i.rd, fields_i.opcode};
        bad  = (imm[11:0] != 12'd0);
      end
      FMT_J: begin
        word = {imm[20], imm[10:1], imm[11], imm[19:12], fields_i.rd, fields_i.opcode};
        bad  = (imm_s < IMMJ_MIN) || (imm_s > IMMJ_MAX) || imm[0];
      end
      default: bad = 1'b1;
    endcase
    // Every RV32I opcode has its two low bits set.
    if (fields_i.opcode[1:0] != 2'b11) bad = 1'b1;
  end

  assign err_o   = bad;
  assign instr_o = bad ? 32'h0000_0000 : word;

endmodule

// File: rtl/instr_encoder.sv
// Two-stage elastic RV32I instruction encoder: S1 holds the decoded fields,
// S2 holds the packed word and its error flag; a saturating counter tallies errors.
module instr_encoder
  import riscv_pkg::*;
#(
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           in_fmt,
  input  logic [6:0]           in_opcode,
  input  logic [4:0]           in_rd,
  input  logic [4:0]           in_rs1,
  input  logic [4:0]           in_rs2,
  input  logic [2:0]           in_funct3,
  input  logic [6:0]           in_funct7,
  input  logic [31:0]          in_imm,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_instr,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  fields_t                s1_q;
  logic                   s1_vld_q;
  logic                   s2_vld_q;
  logic [31:0]            s2_instr_q;
  logic                   s2_err_q;
  logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic [31:0]            pack_instr;
  logic                   pack_err;
  logic                   in_acc, out_acc, s2_adv;

  assign out_acc  = s2_vld_q && out_ready;
  assign s2_adv   = s1_vld_q && (!s2_vld_q || out_ready);
  assign in_ready = !s1_vld_q || s2_adv;
  assign in_acc   = in_valid && in_ready;

  // S1: capture fields; data needs no reset because s1_vld_q guards it.
  always_ff @(posedge clk) begin
    if (in_acc) begin
      s1_q <= '{fmt: in_fmt, opcode: in_opcode, rd: in_rd, rs1: in_rs1, rs2: in_rs2,
                funct3: in_funct3, funct7: in_funct7, imm: in_imm};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      s1_vld_q <= 1'b0;
    else if (in_acc) s1_vld_q <= 1'b1;
    else if (s2_adv) s1_vld_q <= 1'b0;
  end

  imm_pack u_imm_pack (
    .fields_i (s1_q),
    .instr_o  (pack_instr),
    .err_o    (pack_err)
  );

  // S2: packed word; held while valid and not accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_vld_q   <= 1'b0;
      s2_instr_q <= '0;
      s2_err_q   <= 1'b0;
    end else if (s2_adv) begin
      s2_vld_q   <= 1'b1;
      s2_instr_q <= pack_instr;
      s2_err_q   <= pack_err;
    end else if (out_acc) begin
      s2_vld_q   <= 1'b0;
    end
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (out_acc && s2_err_q && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_cnt_q <= '0;
    else        err_cnt_q <= err_cnt_d;
  end

  assign out_valid = s2_vld_q;
  assign out_instr = s2_instr_q;
  assign out_err   = s2_err_q;
  assign err_count = err_cnt_q;

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the immediate generator: assembles a 32-bit RV32I instruction word from its decoded fields (format, opcode, rd, rs1, rs2, funct3, funct7, immediate).
- Scatters the immediate into the format-specific bit positions and range-checks it.
- Elastic two-stage pipeline with valid/ready handshakes on both sides.
- Feeds the instruction-stream generator / self-checking loop in front of the decoder and imm_gen benches.

Parameters:
- ERR_CNT_W, 16, width of the saturating error counter.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input fields valid.
- in_ready  out  1  encoder can accept fields this cycle.
- in_fmt  in  3  format code: R=0, I=1, S=2, B=3, U=4, J=5; 6 and 7 are illegal.
- in_opcode  in  7  opcode field.
- in_rd  in  5  destination register.
- in_rs1  in  5  source register 1.
- in_rs2  in  5  source register 2.
- in_funct3  in  3  funct3 field.
- in_funct7  in  7  funct7 field (R only).
- in_imm  in  32  immediate as a sign-extended byte value; for U, the full upper value.
- out_valid  out  1  encoded word valid.
- out_ready  in  1  consumer accepts the word.
- out_instr  out  32  encoded instruction.
- out_err  out  1  encoding error for this word.
- err_count  out  ERR_CNT_W  number of words delivered with out_err=1, saturating.

Behaviour:
- Reset (async assert, sync release): both stage valids = 0, out_valid = 0, out_instr = 0, out_err = 0, err_count = 0.
  - Reset mid-transfer discards any in-flight words.
- Handshake: a transfer occurs on a cycle with valid && ready.
  - Once out_valid is high, out_instr and out_err hold stable until accepted.
  - in_ready must not depend combinationally on in_valid.
- Stage 1 (S1) captures the input fields when in_ready && in_valid.
- Stage 2 (S2) registers the packed word and its error flag.
- Latency: accept at cycle N gives out_valid at N+2. Throughput is 1 word/cycle while out_ready is held high.
- Advance rules:
  - S2 loads from S1 when S1 is valid and (S2 is empty or S2 is being accepted).
  - in_ready = !S1_valid || S1 advancing.
  - Simultaneous input accept and output accept both complete in the same cycle; no bubble and no loss.
- Packing (bit ranges are imm bits):
  - R: {funct7, rs2, rs1, funct3, rd, opcode}; in_imm ignored.
  - I: {imm[11:0], rs1, funct3, rd, opcode}.
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
  - U: {imm[31:12], rd, opcode}.
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
- Error conditions (any one sets err):
  - I/S: imm outside -2048..2047.
  - B: imm outside -4096..4094, or imm[0] = 1.
  - J: imm outside -1048576..1048574, or imm[0] = 1.
  - U: imm[11:0] != 0.
  - in_fmt is 6 or 7.
  - opcode[1:0] != 2'b11.
- Error output: out_instr = 32'h0000_0000 and out_err = 1. The word is still delivered; the pipeline does not stall.
- err_count increments on each accepted output with out_err = 1 and saturates at all-ones.

Decomposition:
- Package riscv_pkg:
  - fmt_e enum for the format codes.
  - Opcode constants: OP, OP_IMM, LOAD, STORE, BRANCH, LUI, AUIPC, JAL, JALR.
  - Immediate range constants per format.
- Sub-module imm_pack (combinational): fields in, {instr[31:0], err} out. Instantiated between S1 and S2.

Test Plan:
- I, addi x1,x0,5: fmt=1, op=0010011, rd=1, f3=0, imm=5 -> out_instr 0x00500093, err 0, out_valid exactly 2 cycles after accept.
- S and B:
  - sw x2,8(x1) -> 0x0020A423.
  - beq x0,x0,-4 (imm=32'hFFFFFFFC) -> 0xFE000EE3.
- U and J:
  - lui x1 with imm=0x12345000 -> 0x123450B7.
  - jal x1 with imm=2048 -> 0x001000EF.
- Errors, err_count -> 4 after all are accepted:
  - B with imm=3 -> out_instr 0, err 1.
  - I with imm=2048 -> err 1.
  - U with imm=0x00000001 -> err 1.
  - fmt=7 -> err 1.
- Backpressure: stream 6 words with out_ready low for 5 cycles.
  - in_ready drops after 2 accepts.
  - After release, all 6 words emerge in order with no duplicates, then 1 word/cycle.
- Reset with both stages full: out_valid drops immediately on rst_n low; after release, in_ready=1 and err_count=0.
